// File: rtl/simd_mem_pkg.sv
// simd_mem_pkg: shared types, default sizes and per-core bus slicing for the
// MatrixMul SIMD RAM arbiters.
package simd_mem_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam int DEF_NCORES = 4;
    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;
    localparam int SLICE_MAX_W = 32;
    localparam int BUS_MAX_W = 8 * SLICE_MAX_W;
    // Caller zero-extends the packed bus and truncates the result to its width
    function automatic logic [SLICE_MAX_W-1:0] core_slice(input logic [BUS_MAX_W-1:0] bus,
                                                          input int i, input int w);
        return SLICE_MAX_W'(bus >> (i * w));
    endfunction
endpackage

// File: rtl/simd_ram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; first requester at or after ptr,
// wrapping modulo N. Shared with the DRAM-side arbiter.
module rr_pick #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] j;
    always_comb begin
        idx = '0;
        j = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % N);
            if (req[j]) idx = j;
        end
        onehot = (|req) ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/simd_ram_arbiter.sv
// simd_ram_arbiter: round-robin sequencer sharing one synchronous RAM between
// NCORES SIMD cores. Define SIMD_RAM_BROADCAST_EN to merge same-address reads.
module simd_ram_arbiter
    import simd_mem_pkg::*;
#(
    parameter int NCORES = DEF_NCORES,
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCORES-1:0]    req,
    input  logic [NCORES-1:0]    wren,
    input  logic [NCORES*AW-1:0] addr,
    input  logic [NCORES*DW-1:0] din,
    input  logic                 dram_busy,
    output logic [NCORES-1:0]    grant,
    output logic [NCORES-1:0]    rvalid,
    output logic [DW-1:0]        dq,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_din,
    output logic                 ram_wren,
    input  logic [DW-1:0]        ram_q
);
    localparam int IW = $clog2(NCORES);

    state_t            state_q, state_d;
    logic [NCORES-1:0] served_q, served_d, win_oh, mask;
    logic [IW-1:0]     ptr_q, ptr_d, win_idx;
    logic              wr_q, wr_d, arb;
    logic [AW-1:0]     ram_addr_q, ram_addr_d, win_addr;
    logic [DW-1:0]     ram_din_q, ram_din_d;

    rr_pick #(.N(NCORES)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .onehot(win_oh),
        .idx   (win_idx)
    );

    always_comb begin
        win_addr = AW'(core_slice(BUS_MAX_W'(addr), int'(win_idx), AW));
        mask = win_oh;
`ifdef SIMD_RAM_BROADCAST_EN
        for (int i = 0; i < NCORES; i++)
            if (!wren[win_idx] && req[i] && !wren[i] &&
                AW'(core_slice(BUS_MAX_W'(addr), i, AW)) == win_addr)
                mask[i] = 1'b1;
`endif
        // IDLE and RESP are both arbitration points, giving back-to-back accesses
        arb = (state_q != ACCESS) && !dram_busy && (|req);
        state_d = arb ? ACCESS : (state_q == ACCESS) ? RESP : IDLE;
        served_d = arb ? mask : (state_q == ACCESS) ? served_q : '0;
        wr_d = arb ? wren[win_idx] : (state_q == ACCESS) && wr_q;
        ptr_d = arb ? ((win_idx == IW'(NCORES - 1)) ? '0 : win_idx + 1'b1) : ptr_q;
        ram_addr_d = arb ? win_addr : ram_addr_q;
        ram_din_d = arb ? DW'(core_slice(BUS_MAX_W'(din), int'(win_idx), DW)) : ram_din_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            served_q <= '0;
            wr_q <= 1'b0;
            ptr_q <= '0;
            ram_addr_q <= '0;
            ram_din_q <= '0;
        end else begin
            state_q <= state_d;
            served_q <= served_d;
            wr_q <= wr_d;
            ptr_q <= ptr_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q <= ram_din_d;
        end
    end

    assign grant = (state_q == ACCESS) ? served_q : '0;
    assign rvalid = (state_q == RESP && !wr_q) ? served_q : '0;
    assign ram_wren = (state_q == ACCESS) && wr_q;
    assign ram_addr = ram_addr_q;
    assign ram_din = ram_din_q;
    assign dq = ram_q;
endmodule

// File: tb/tb_simd_ram_arbiter.sv
// tb_simd_ram_arbiter: scoreboard bench; expected grants and read responses are
// queued as cores issue requests and popped as the arbiter produces them.
module tb_simd_ram_arbiter;
    logic        clk, rst, dram_busy;
    logic [3:0]  req, wren, grant, rvalid;
    logic [31:0] addr, din;
    logic [7:0]  dq, ram_addr, ram_din, ram_q;
    logic        ram_wren;
    logic [7:0]  mem [256];

    typedef struct {
        logic [3:0] mask;
        logic       wr;
        logic [7:0] a;
        logic [7:0] d;
    } gexp_t;
    typedef struct {
        logic [3:0] mask;
        logic [7:0] data;
    } rexp_t;

    gexp_t exp_gnt[$];
    rexp_t exp_rd[$];
    int errs = 0, checks = 0, cyc = 0, last_gnt_cyc = 0;
    int rr_left[4];
    logic [3:0] reraise;
    bit got_gnt, check_gap, gap_armed;

    simd_ram_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .wren(wren), .addr(addr), .din(din),
        .dram_busy(dram_busy), .grant(grant), .rvalid(rvalid), .dq(dq),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_din;
        ram_q <= mem[ram_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic issue(input int c, input logic wr, input logic [7:0] a, input logic [7:0] d);
        req[c] = 1'b1;
        wren[c] = wr;
        addr[c*8 +: 8] = a;
        din[c*8 +: 8] = d;
    endtask

    task automatic exp_g(input logic [3:0] m, input logic wr, input logic [7:0] a, input logic [7:0] d);
        exp_gnt.push_back('{m, wr, a, d});
    endtask

    task automatic exp_r(input logic [3:0] m, input logic [7:0] data);
        exp_rd.push_back('{m, data});
    endtask

    task automatic step();
        gexp_t g;
        rexp_t r;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++)
            if (reraise[i]) begin
                req[i] = 1'b1;
                reraise[i] = 1'b0;
            end
        got_gnt = (grant != 0);
        if (grant != 0) begin
            if (exp_gnt.size() == 0) chk("grant_unexpected", grant, 0);
            else begin
                g = exp_gnt.pop_front();
                chk("grant", grant, g.mask);
                chk("ram_wren", ram_wren, g.wr);
                chk("ram_addr", ram_addr, g.a);
                if (g.wr) chk("ram_din", ram_din, g.d);
            end
            if (check_gap && gap_armed) chk("grant_gap", cyc - last_gnt_cyc, 2);
            gap_armed = 1;
            last_gnt_cyc = cyc;
            for (int i = 0; i < 4; i++)
                if (grant[i]) begin
                    req[i] = 1'b0;
                    if (rr_left[i] > 0) begin
                        rr_left[i]--;
                        reraise[i] = 1'b1;
                    end
                end
        end else if (ram_wren) chk("wren_without_grant", ram_wren, 0);
        if (rvalid != 0) begin
            if (exp_rd.size() == 0) chk("rvalid_unexpected", rvalid, 0);
            else begin
                r = exp_rd.pop_front();
                chk("rvalid", rvalid, r.mask);
                chk("dq", dq, r.data);
            end
        end
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40; k++) begin
            if (exp_gnt.size() == 0 && exp_rd.size() == 0) break;
            step();
        end
        chk({tag, "_grants_left"}, exp_gnt.size(), 0);
        chk({tag, "_reads_left"}, exp_rd.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1;
        req = '0;
        wren = '0;
        reraise = '0;
        exp_gnt.delete();
        exp_rd.delete();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        rst = 1; req = '0; wren = '0; addr = '0; din = '0; dram_busy = 0;
        reraise = '0; check_gap = 0; gap_armed = 0; ram_q = '0;
        for (int i = 0; i < 4; i++) rr_left[i] = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h3C] = 8'hA5;
        mem[8'h20] = 8'h77;
        for (int i = 0; i < 4; i++) mem[8'h40 + i] = 8'h90 + 8'(i);
        do_reset();
        chk("rst_grant", grant, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_wren", ram_wren, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_din", ram_din, 0);

        // single read
        issue(2, 0, 8'h3C, 8'h00);
        exp_g(4'b0100, 0, 8'h3C, 8'h00);
        exp_r(4'b0100, 8'hA5);
        drain("single_read");

        // write then read back
        issue(1, 1, 8'h10, 8'h5A);
        exp_g(4'b0010, 1, 8'h10, 8'h5A);
        drain("write");
        issue(1, 0, 8'h10, 8'h00);
        exp_g(4'b0010, 0, 8'h10, 8'h00);
        exp_r(4'b0010, 8'h5A);
        drain("readback");

        // fairness from pointer 0, back-to-back grants every 2 cycles
        do_reset();
        for (int i = 0; i < 4; i++) issue(i, 0, 8'h40 + 8'(i), 8'h00);
        rr_left[0] = 1;
        rr_left[1] = 1;
        for (int n = 0; n < 6; n++) begin
            exp_g(4'(1 << (n % 4)), 0, 8'h40 + 8'(n % 4), 8'h00);
            exp_r(4'(1 << (n % 4)), 8'h90 + 8'(n % 4));
        end
        check_gap = 1;
        gap_armed = 0;
        drain("fairness");
        check_gap = 0;

        // dram_busy holds off arbitration in IDLE
        dram_busy = 1;
        issue(0, 0, 8'h3C, 8'h00);
        exp_g(4'b0001, 0, 8'h3C, 8'h00);
        exp_r(4'b0001, 8'hA5);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("busy_no_grant", grant, 0);
        end
        dram_busy = 0;
        step();
        chk("release_grant", grant, 4'b0001);
        drain("hold");

        // dram_busy raised during ACCESS lets the read complete
        issue(0, 0, 8'h10, 8'h00);
        exp_g(4'b0001, 0, 8'h10, 8'h00);
        exp_r(4'b0001, 8'h5A);
        for (int k = 0; k < 10; k++) begin
            step();
            if (got_gnt) break;
        end
        dram_busy = 1;
        issue(1, 0, 8'h3C, 8'h00);
        step();
        chk("busy_rvalid", rvalid, 4'b0001);
        step();
        chk("busy_blocks_core1", grant, 0);
        exp_g(4'b0010, 0, 8'h3C, 8'h00);
        exp_r(4'b0010, 8'hA5);
        dram_busy = 0;
        drain("busy_access");

        // async reset in ACCESS abandons the read
        do_reset();
        issue(2, 0, 8'h3C, 8'h00);
        exp_g(4'b0100, 0, 8'h3C, 8'h00);
        for (int k = 0; k < 10; k++) begin
            step();
            if (got_gnt) break;
        end
        chk("midop_in_access", grant, 4'b0100);
        rst = 1;
        #1;
        chk("midop_grant", grant, 0);
        chk("midop_rvalid", rvalid, 0);
        chk("midop_wren", ram_wren, 0);
        chk("midop_addr", ram_addr, 0);
        chk("midop_din", ram_din, 0);
        exp_gnt.delete();
        exp_rd.delete();
        issue(3, 0, 8'h41, 8'h00);
        issue(1, 0, 8'h40, 8'h00);
        exp_g(4'b0010, 0, 8'h40, 8'h00);
        exp_g(4'b1000, 0, 8'h41, 8'h00);
        exp_r(4'b0010, 8'h90);
        exp_r(4'b1000, 8'h91);
        @(posedge clk);
        #1;
        rst = 0;
        drain("midop");

        // three readers and one writer on the same address, pointer at 0
        issue(0, 0, 8'h20, 8'h00);
        issue(1, 0, 8'h20, 8'h00);
        issue(2, 1, 8'h20, 8'hC3);
        issue(3, 0, 8'h20, 8'h00);
`ifdef SIMD_RAM_BROADCAST_EN
        exp_g(4'b1011, 0, 8'h20, 8'h00);
        exp_g(4'b0100, 1, 8'h20, 8'hC3);
        exp_r(4'b1011, 8'h77);
`else
        exp_g(4'b0001, 0, 8'h20, 8'h00);
        exp_g(4'b0010, 0, 8'h20, 8'h00);
        exp_g(4'b0100, 1, 8'h20, 8'hC3);
        exp_g(4'b1000, 0, 8'h20, 8'h00);
        exp_r(4'b0001, 8'h77);
        exp_r(4'b0010, 8'h77);
        exp_r(4'b1000, 8'hC3);
`endif
        drain("broadcast");
        for (int k = 0; k < 3; k++) step();
        chk("final_idle_grant", grant, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
